// File: rtl/bus_router_pkg.sv
// ============================================================================
// Module      : bus_router_pkg
// Description : Shared types and region-map checks for the bus address router
//               family (FSM state encoding, alignment/overlap helpers).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_router_pkg;

    // Router transaction state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } router_state_e;

    // Width of each entry in the base/size parameter tables
    localparam int REGION_FIELD_W = 32;

    // A region is aligned when no base bit falls inside its size mask
    function automatic bit region_aligned(
        input logic [REGION_FIELD_W-1:0] base,
        input int unsigned               size_log2
    );
        logic [REGION_FIELD_W-1:0] mask;
        if (size_log2 >= REGION_FIELD_W) begin
            mask = '1;
        end else begin
            mask = (32'd1 << size_log2) - 32'd1;
        end
        return (base & mask) == '0;
    endfunction

    // Two aligned power-of-two regions overlap exactly when the larger one
    // contains the base of the smaller one.
    function automatic bit regions_overlap(
        input logic [REGION_FIELD_W-1:0] base_a,
        input int unsigned               log_a,
        input logic [REGION_FIELD_W-1:0] base_b,
        input int unsigned               log_b
    );
        int unsigned big;
        big = (log_a > log_b) ? log_a : log_b;
        if (big >= REGION_FIELD_W) begin
            return 1'b1;
        end
        return (base_a >> big) == (base_b >> big);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addr_region_decode.sv
// ============================================================================
// Module      : addr_region_decode
// Description : Combinational address decoder. Matches the address against
//               aligned power-of-two regions, returns a lowest-index-priority
//               one-hot hit vector, an any-hit flag and the region offset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_region_decode
    import bus_router_pkg::*;
#(
    parameter int ADDR_WIDTH        = 16,
    parameter int MAPPED_ADDR_WIDTH = 12,
    parameter int SLAVE_NUM         = 4,
    parameter logic [SLAVE_NUM-1:0][REGION_FIELD_W-1:0] SLAVE_BASE =
        {32'h4000, 32'h2000, 32'h1000, 32'h0000},
    parameter logic [SLAVE_NUM-1:0][REGION_FIELD_W-1:0] SLAVE_SIZE_LOG2 =
        {32'd12, 32'd13, 32'd12, 32'd12}
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    output logic [SLAVE_NUM-1:0]         hit,
    output logic                         any_hit,
    output logic [MAPPED_ADDR_WIDTH-1:0] offset
);

    logic [REGION_FIELD_W-1:0]                       addr_ext;
    logic [SLAVE_NUM-1:0]                            raw_hit;
    logic [SLAVE_NUM-1:0][MAPPED_ADDR_WIDTH-1:0]     region_offset;

    assign addr_ext = REGION_FIELD_W'(addr);

    if (ADDR_WIDTH > REGION_FIELD_W) begin : g_bad_addr_width
        $error("addr_region_decode: ADDR_WIDTH wider than region table entries");
    end

    for (genvar j = 0; j < SLAVE_NUM; j++) begin : g_region
        localparam int unsigned               SZ   = SLAVE_SIZE_LOG2[j];
        localparam logic [REGION_FIELD_W-1:0] MASK =
            (SZ >= REGION_FIELD_W) ? '1 : ((32'd1 << SZ) - 32'd1);

        // Mask match: compare only the bits above the region size
        assign raw_hit[j]       = (SZ >= REGION_FIELD_W) ? 1'b1 :
                                  ((addr_ext >> SZ) == (SLAVE_BASE[j] >> SZ));
        assign region_offset[j] = MAPPED_ADDR_WIDTH'(addr_ext & MASK);

        if (!region_aligned(SLAVE_BASE[j], SZ)) begin : g_misaligned
            $error("addr_region_decode: region %0d base not aligned to its size", j);
        end

        for (genvar k = j + 1; k < SLAVE_NUM; k++) begin : g_pair
            if (regions_overlap(SLAVE_BASE[j], SZ, SLAVE_BASE[k], SLAVE_SIZE_LOG2[k])) begin : g_overlap
                $error("addr_region_decode: regions %0d and %0d overlap", j, k);
            end
        end
    end

    // Priority pick: scanning downward lets the lowest matching index win
    always_comb begin
        hit    = '0;
        offset = '0;
        for (int j = SLAVE_NUM - 1; j >= 0; j--) begin
            if (raw_hit[j]) begin
                hit    = '0;
                hit[j] = 1'b1;
                offset = region_offset[j];
            end
        end
    end

    assign any_hit = |raw_hit;

endmodule

`default_nettype wire

// File: rtl/bus_addr_router.sv
// ============================================================================
// Module      : bus_addr_router
// Description : Single-master to N-slave router. Decodes the master address,
//               registers the one-hot select and region offset, holds the
//               transfer until the selected slave acks, and reports a bus
//               error for unmapped addresses or ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_addr_router
    import bus_router_pkg::*;
#(
    parameter int ADDR_WIDTH        = 16,
    parameter int MAPPED_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_NUM         = 4,
    parameter logic [SLAVE_NUM-1:0][REGION_FIELD_W-1:0] SLAVE_BASE =
        {32'h4000, 32'h2000, 32'h1000, 32'h0000},
    parameter logic [SLAVE_NUM-1:0][REGION_FIELD_W-1:0] SLAVE_SIZE_LOG2 =
        {32'd12, 32'd13, 32'd12, 32'd12},
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            m_req,
    input  logic                            m_we,
    input  logic [ADDR_WIDTH-1:0]           m_addr,
    input  logic [DATA_WIDTH-1:0]           m_wdata,
    output logic                            m_ready,
    output logic                            m_rvalid,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic                            m_err,
    output logic [SLAVE_NUM-1:0]            s_sel,
    output logic                            s_we,
    output logic [MAPPED_ADDR_WIDTH-1:0]    s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic [SLAVE_NUM-1:0]            s_ack,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] s_rdata
);

    // A zero timeout disables the check; keep the counter at least one bit
    localparam bit            TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam int            CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (SLAVE_NUM < 1) begin : g_bad_slave_num
        $error("bus_addr_router: SLAVE_NUM must be at least 1");
    end

    router_state_e                  state_q, state_d;
    logic [SLAVE_NUM-1:0]           sel_q, sel_d;
    logic                           we_q, we_d;
    logic [MAPPED_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic                           rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic                           err_q, err_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [SLAVE_NUM-1:0]           dec_hit;
    logic                           dec_any_hit;
    logic [MAPPED_ADDR_WIDTH-1:0]   dec_offset;
    logic                           ack_hit;
    logic [DATA_WIDTH-1:0]          sel_rdata;

    addr_region_decode #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .MAPPED_ADDR_WIDTH (MAPPED_ADDR_WIDTH),
        .SLAVE_NUM         (SLAVE_NUM),
        .SLAVE_BASE        (SLAVE_BASE),
        .SLAVE_SIZE_LOG2   (SLAVE_SIZE_LOG2)
    ) u_decode (
        .addr    (m_addr),
        .hit     (dec_hit),
        .any_hit (dec_any_hit),
        .offset  (dec_offset)
    );

    // Only the latched slave's ack counts; others are masked off
    assign ack_hit = |(s_ack & sel_q);

    // AND-OR read-data mux driven by the registered one-hot select
    always_comb begin
        sel_rdata = '0;
        for (int j = 0; j < SLAVE_NUM; j++) begin
            if (sel_q[j]) begin
                sel_rdata = sel_rdata | s_rdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output computation for the transfer FSM
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    if (dec_any_hit) begin
                        sel_d   = dec_hit;
                        addr_d  = dec_offset;
                        we_d    = m_we;
                        wdata_d = m_wdata;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end

            ST_ISSUE, ST_WAIT: begin
                if (ack_hit) begin
                    rdata_d  = sel_rdata;
                    rvalid_d = 1'b1;
                    sel_d    = '0;
                    state_d  = ST_IDLE;
                end else if (TIMEOUT_EN && (state_q == ST_WAIT) && (cnt_q >= TIMEOUT_VAL)) begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    sel_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_ERR: begin
                rdata_d  = '0;
                rvalid_d = 1'b1;
                err_d    = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_ready  = (state_q == ST_IDLE);
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;
    assign m_err    = err_q;
    assign s_sel    = sel_q;
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: doc/bus_addr_router.md
Name: bus_addr_router

Overview:
Single-master to N-slave bus router and address decoder, the pipelined successor to comparator-based linear slice mapping.
- Decodes each slave region by aligned base/size (power-of-two mask match), not magnitude comparators.
- Registers the one-hot select and the region-relative address, then holds the transaction until the selected slave acknowledges.
- Returns a bus error for unmapped addresses or slave timeout.
- Sits between the CPU data port and peripheral/memory slaves.

Parameters:
- ADDR_WIDTH, 16, master address width
- MAPPED_ADDR_WIDTH, 12, width of the region-relative address driven to slaves
- DATA_WIDTH, 32, read/write data width
- SLAVE_NUM, 4, number of slave regions (>=1)
- SLAVE_BASE[SLAVE_NUM], {0x0000,0x1000,0x2000,0x4000}, region base addresses; each must be aligned to its size
- SLAVE_SIZE_LOG2[SLAVE_NUM], {12,12,13,12}, log2 of region size in bytes
- TIMEOUT_CYCLES, 255, cycles to wait for an ack before erroring; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_req  in  1  master request
- m_we  in  1  write enable
- m_addr  in  ADDR_WIDTH  master address
- m_wdata  in  DATA_WIDTH  write data
- m_ready  out  1  router can accept a request (state IDLE)
- m_rvalid  out  1  one-cycle response pulse
- m_rdata  out  DATA_WIDTH  read data, valid with m_rvalid
- m_err  out  1  error flag, valid with m_rvalid
- s_sel  out  SLAVE_NUM  one-hot slave select
- s_we  out  1  registered write enable
- s_addr  out  MAPPED_ADDR_WIDTH  registered region-relative address
- s_wdata  out  DATA_WIDTH  registered write data
- s_ack  in  SLAVE_NUM  per-slave completion
- s_rdata  in  DATA_WIDTH x SLAVE_NUM  per-slave read data

Behaviour:
- Reset (asynchronous): state IDLE; s_sel, s_we, s_addr, s_wdata, m_rvalid, m_rdata, m_err and the timeout counter all 0. m_ready=1 after reset.
- Decode (combinational, in IDLE):
  - hit[j] = (m_addr >> SLAVE_SIZE_LOG2[j]) == (SLAVE_BASE[j] >> SLAVE_SIZE_LOG2[j]).
  - Offset = m_addr & (2^SIZE_LOG2[j] - 1), zero-extended or truncated to MAPPED_ADDR_WIDTH.
  - Several hits: the lowest index wins. Overlapping or misaligned regions are an elaboration-time error.
- FSM states: IDLE, ISSUE, WAIT, ERR.
  - IDLE: if m_req and any hit, latch sel/offset/we/wdata and go to ISSUE. If m_req and no hit, go to ERR. m_ready=1 only in IDLE.
  - ISSUE and WAIT: s_sel holds the latched one-hot.
    - s_ack[latched] seen: latch m_rdata=s_rdata[latched], m_err=0, pulse m_rvalid next cycle, clear s_sel, go to IDLE.
    - No ack: ISSUE goes to WAIT, and the counter increments.
  - WAIT timeout: counter reaching TIMEOUT_CYCLES (nonzero) without ack gives m_rvalid=1, m_err=1, m_rdata=0, clear s_sel, go to IDLE.
  - ERR: one cycle, drives m_rvalid=1, m_err=1, m_rdata=0; next state IDLE.
- Latency:
  - Request accepted at cycle 0; s_sel is high from cycle 1.
  - Ack at cycle k gives m_rvalid at cycle k+1, with m_ready=1 in that same cycle, so back-to-back requests are accepted.
  - Unmapped request at cycle 0 gives the error pulse at cycle 2.
- Outputs: m_rvalid, m_err and m_rdata are registered and pulse exactly one cycle. m_rdata holds its value otherwise.
- Acks from non-selected slaves are ignored.
- m_req while not IDLE is ignored; the master must hold m_req until it sees m_ready.
- Counter width is $clog2(TIMEOUT_CYCLES+1), saturating; it is cleared on entry to ISSUE.
- SLAVE_NUM==1: decode still applies, so an out-of-region address errors.

Decomposition:
- Package bus_router_pkg holds:
  - state enum router_state_e;
  - the region-check function (alignment and overlap) used in elaboration asserts.
- Sub-module addr_region_decode: purely combinational. Takes addr and outputs the hit one-hot (lowest-index priority), any_hit and the mapped offset. Reusable by future multi-master routers.

Test Plan:
- Read 0x1234, slave1 acks at cycle 3 with 0xDEADBEEF -> s_sel=0b0010 and s_addr=0x234 at cycles 1-3; m_rvalid=1, m_rdata=0xDEADBEEF, m_err=0 at cycle 4.
- Write 0x3FFC data 0x55, slave2 acks immediately at cycle 1 -> s_sel=0b0100, s_addr=0xFFC (13-bit offset truncated to 12), s_we=1; m_rvalid at cycle 2.
- Access 0x8000 (unmapped) -> no s_sel activity; m_rvalid=1, m_err=1, m_rdata=0 at cycle 2.
- Read 0x4010, slave3 never acks, TIMEOUT_CYCLES=4 -> m_err pulse after 4 wait cycles; s_sel returns to 0 and m_ready=1.
- Slave0 acks spuriously while slave3 is selected -> ignored, no m_rvalid. Back-to-back requests on the m_ready cycle are accepted without a bubble.
- Assert rst during WAIT -> s_sel=0 and m_rvalid=0 immediately; state IDLE; a later ack is ignored.
